// File: rtl/mem_block_mover_if.sv
// Memory-unit bus between the block mover (master) and memory_unit (slave).
// The master drives write enable, address and write data; the memory returns read data.
interface mem_block_mover_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (output we, output address, output write_data, input read_data);
    modport slave  (input we, input address, input write_data, output read_data);
endinterface

// File: rtl/mem_block_mover.sv
// Block COPY / FILL engine that masters the memory_unit bus.
// A one-cycle start in IDLE launches a command; busy/done/words_done report progress.
module mem_block_mover #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  words_done,
    mem_block_mover_if.master     mem
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_CAPT,
        WR,
        DONE
    } state_t;

    typedef struct packed {
        logic                  fill;
        logic [DATA_WIDTH-1:0] value;
    } cmd_t;

    state_t                state, state_nxt;
    cmd_t                  cmd;
    logic [ADDR_WIDTH-1:0] cur_src, cur_dst;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0] buf_q;
    logic [DATA_WIDTH-1:0] wdata_last;
    logic [DATA_WIDTH-1:0] wdata_sel;
    logic                  accept;
    logic                  last_word;

    assign accept    = (state == IDLE) && start;
    assign last_word = (remaining == LEN_WIDTH'(1));
    assign wdata_sel = cmd.fill ? cmd.value : buf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd        <= '0;
            cur_src    <= '0;
            cur_dst    <= '0;
            remaining  <= '0;
            buf_q      <= '0;
            wdata_last <= '0;
            words_done <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd.fill   <= mode;
                cmd.value  <= fill_value;
                cur_src    <= src_addr;
                cur_dst    <= dst_addr;
                remaining  <= length;
                words_done <= '0;
            end
            // Capturing at the end of the second read cycle covers both comb and registered memories.
            if (state == RD_CAPT)
                buf_q <= mem.read_data;
            if (state == WR) begin
                cur_src    <= cur_src + 1'b1;
                cur_dst    <= cur_dst + 1'b1;
                remaining  <= remaining - 1'b1;
                words_done <= words_done + 1'b1;
                wdata_last <= wdata_sel;
            end
        end
    end

    // Next state plus Moore outputs; the bus never sees a combinational path from inputs.
    always_comb begin
        state_nxt      = state;
        busy           = 1'b0;
        done           = 1'b0;
        mem.we         = 1'b0;
        mem.address    = '0;
        mem.write_data = wdata_last;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0)
                        state_nxt = DONE;
                    else if (mode)
                        state_nxt = WR;
                    else
                        state_nxt = RD_ADDR;
                end
            end
            RD_ADDR: begin
                busy        = 1'b1;
                mem.address = cur_src;
                state_nxt   = RD_CAPT;
            end
            RD_CAPT: begin
                busy        = 1'b1;
                mem.address = cur_src;
                state_nxt   = WR;
            end
            WR: begin
                busy           = 1'b1;
                mem.we         = 1'b1;
                mem.address    = cur_dst;
                mem.write_data = wdata_sel;
                if (last_word)
                    state_nxt = DONE;
                else if (cmd.fill)
                    state_nxt = WR;
                else
                    state_nxt = RD_ADDR;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_block_mover.sv
// Scoreboard bench for mem_block_mover against a sync-write / comb-read memory model.
module tb_mem_block_mover;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] length = '0;
    logic [DW-1:0] fill_value = '0;
    logic          busy, done;
    logic [LW-1:0] words_done;

    mem_block_mover_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_block_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    // memory model; the preload port shares the write process with the DUT bus
    logic [DW-1:0] mem [0:255];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (bus.we) mem[bus.address] <= bus.write_data;
    end
    assign bus.read_data = mem[bus.address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
    typedef struct {int w; int c;} dn_t;
    wr_t exp_wr[$];
    dn_t exp_dn[$];
    int  errors = 0;
    int  checks = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor: every bus write and every done pulse must match the head of its queue
    always @(negedge clk) begin
        wr_t e;
        dn_t d;
        if (mon_en) begin
            if (bus.we) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             bus.address, bus.write_data);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", bus.address, e.a);
                    chk("wr_data", bus.write_data, e.d);
                    chk("busy_in_wr", busy, 1);
                end
            end
            if (done) begin
                if (exp_dn.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    d = exp_dn.pop_front();
                    chk("done_words", words_done, d.w);
                    chk("done_cycle", cyc, d.c);
                    chk("busy_in_done", busy, 0);
                end
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk); pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk); pl_we = 1'b0;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.a = a; e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic push_dn(input int w, input int c);
        dn_t d;
        d.w = w; d.c = c;
        exp_dn.push_back(d);
    endtask

    // start is raised at a negedge; lat is the hand-computed cycle count to done
    task automatic issue(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] dd,
                         input logic [LW-1:0] n, input logic [DW-1:0] f,
                         input bit exp_done, input int w, input int lat);
        @(negedge clk);
        start = 1'b1; mode = m; src_addr = s; dst_addr = dd; length = n; fill_value = f;
        if (exp_done) push_dn(w, cyc + lat);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k;
        for (k = 0; k < 1000; k++) begin
            if (exp_dn.size() == 0 && exp_wr.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (k == 1000) begin
            errors++;
            $display("FAIL timeout_%s: got %0d writes %0d dones outstanding expected 0",
                     nm, exp_wr.size(), exp_dn.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_words_done", words_done, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_address", bus.address, 0);
        chk("rst_write_data", bus.write_data, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // 1: FILL A0..A3
        preload(8'hA4, 16'h7777);
        issue(1'b1, 8'h00, 8'hA0, 9'd4, 16'h1234, 1'b1, 4, 5);
        push_wr(8'hA0, 16'h1234); push_wr(8'hA1, 16'h1234);
        push_wr(8'hA2, 16'h1234); push_wr(8'hA3, 16'h1234);
        drain("fill");
        chk("fill_mem_a0", mem[8'hA0], 16'h1234);
        chk("fill_mem_a3", mem[8'hA3], 16'h1234);
        chk("fill_mem_a4_untouched", mem[8'hA4], 16'h7777);
        chk("fill_words_hold", words_done, 4);
        chk("fill_we_idle", bus.we, 0);

        // 2: COPY 10..12 -> 40..42
        preload(8'h10, 16'hAAAA); preload(8'h11, 16'hBBBB); preload(8'h12, 16'hCCCC);
        preload(8'h43, 16'h4343);
        issue(1'b0, 8'h10, 8'h40, 9'd3, 16'h0000, 1'b1, 3, 10);
        push_wr(8'h40, 16'hAAAA); push_wr(8'h41, 16'hBBBB); push_wr(8'h42, 16'hCCCC);
        drain("copy");
        chk("copy_mem_41", mem[8'h41], 16'hBBBB);
        chk("copy_mem_43_untouched", mem[8'h43], 16'h4343);
        chk("copy_src_10", mem[8'h10], 16'hAAAA);
        chk("copy_src_12", mem[8'h12], 16'hCCCC);
        chk("copy_wdata_hold", bus.write_data, 16'hCCCC);

        // 3: FILL wrapping past FF
        preload(8'h02, 16'h1111);
        issue(1'b1, 8'h00, 8'hFE, 9'd4, 16'h5A5A, 1'b1, 4, 5);
        push_wr(8'hFE, 16'h5A5A); push_wr(8'hFF, 16'h5A5A);
        push_wr(8'h00, 16'h5A5A); push_wr(8'h01, 16'h5A5A);
        drain("wrap");
        chk("wrap_mem_00", mem[8'h00], 16'h5A5A);
        chk("wrap_mem_02_untouched", mem[8'h02], 16'h1111);

        // 4: zero-length COPY
        issue(1'b0, 8'h20, 8'h30, 9'd0, 16'h0000, 1'b1, 0, 1);
        drain("len0");
        chk("len0_words", words_done, 0);

        // 5: start while busy and in DONE ignored; start on first IDLE cycle accepted
        preload(8'h60, 16'h6060); preload(8'h90, 16'h9090);
        issue(1'b0, 8'h10, 8'h50, 9'd3, 16'h0000, 1'b1, 3, 10);
        push_wr(8'h50, 16'hAAAA); push_wr(8'h51, 16'hBBBB); push_wr(8'h52, 16'hCCCC);
        repeat (3) @(negedge clk);
        start = 1'b1; mode = 1'b1; dst_addr = 8'h60; length = 9'd2; fill_value = 16'hDEAD;
        @(negedge clk);
        start = 1'b0;
        for (k = 0; k < 100; k++) begin
            if (done) break;
            @(negedge clk);
        end
        checks++;
        if (k == 100) begin
            errors++;
            $display("FAIL timeout_busy_start: got no done expected done within 100 cycles");
        end
        start = 1'b1; mode = 1'b1; dst_addr = 8'h90; length = 9'd1; fill_value = 16'hDEAD;
        @(negedge clk);
        dst_addr = 8'h91; fill_value = 16'hBEEF;
        push_wr(8'h91, 16'hBEEF);
        push_dn(1, cyc + 2);
        @(negedge clk);
        start = 1'b0;
        drain("restart");
        chk("busy_start_mem_60", mem[8'h60], 16'h6060);
        chk("done_start_mem_90", mem[8'h90], 16'h9090);
        chk("idle_start_mem_91", mem[8'h91], 16'hBEEF);

        // 6: reset in WR of word 2 of a 5-word FILL
        preload(8'hC2, 16'h4444);
        issue(1'b1, 8'h00, 8'hC0, 9'd5, 16'h6666, 1'b0, 0, 0);
        push_wr(8'hC0, 16'h6666); push_wr(8'hC1, 16'h6666);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_we", bus.we, 0);
        chk("abort_done", done, 0);
        chk("abort_words", words_done, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        drain("abort");
        chk("abort_mem_c1", mem[8'hC1], 16'h6666);
        chk("abort_mem_c2_untouched", mem[8'hC2], 16'h4444);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
